ssp_rx_deserializer: RTL
========================

# ssp_rx_deserializer

Receive-side deserializer of the SSP: samples the incoming synchronous serial stream (TI synchronous serial frame format, slave clock input) in the PCLK domain, assembles 8-bit frames MSB-first, and hands each completed frame to the receive FIFO with a one-cycle write strobe. It sits directly upstream of the receive FIFO. Its RxData/write_ready outputs connect straight to the FIFO's RxData/write_ready inputs, and the FIFO's full flag (SSPRXINTR) is fed back for overrun detection.

## Interface
- DATA_WIDTH, 8, frame length in bits; also RxData width. Bit counter sized to hold DATA_WIDTH-1.
- PCLK  input  1  system clock; all state updates on rising edge.
- CLEAR_B  input  1  reset, asynchronous assert, active-low; one clock, async active-low reset.
- SSPCLKIN  input  1  serial clock from transmitting peer, ≤ PCLK/2, each level held ≥ 1 PCLK period.
- SSPFSSIN  input  1  frame sync, active-high, one SSPCLKIN period wide, precedes MSB.
- SSPRXD  input  1  serial data; peer drives on SSPCLKIN rise, block samples on fall.
- SSPRXINTR  input  1  receive FIFO full flag.
- RxData  output  DATA_WIDTH  last accepted frame.
- write_ready  output  1  one-PCLK strobe: RxData valid, FIFO writes it.
- rx_overrun  output  1  one-PCLK strobe: frame completed while FIFO full, frame dropped.
- rx_busy  output  1  high while a frame is being shifted in.

## Operation
- Input stage: s_clk, s_fss, s_rxd registered from SSPCLKIN, SSPFSSIN, SSPRXD every PCLK. clk_d is s_clk delayed one PCLK. fall = clk_d & !s_clk. All protocol actions occur only on PCLK edges where fall is true, using s_fss and s_rxd of that cycle.
- States: IDLE, SHIFT. Registers: shift[DATA_WIDTH-2:0], bit_cnt, RxData, write_ready, rx_overrun.
- IDLE: on fall with s_fss=1, go to SHIFT with bit_cnt=0. Any fall with s_fss=0 is ignored.
- SHIFT, fall, bit_cnt < DATA_WIDTH-1: shift <= {shift, s_rxd}, bit_cnt+1. s_fss is ignored here; no resync mid-frame.
- SHIFT, fall, bit_cnt = DATA_WIDTH-1 (LSB):
  - Frame = {shift, s_rxd}.
  - If SSPRXINTR=0: RxData <= frame, write_ready <= 1.
  - If SSPRXINTR=1: RxData unchanged, rx_overrun <= 1.
  - If s_fss=1 on this same fall (back-to-back frames), stay in SHIFT with bit_cnt=0; otherwise go to IDLE.
- write_ready and rx_overrun default to 0 every cycle they are not set. They are never both high.
- RxData holds its value between accepted frames.
- rx_busy = (state == SHIFT).
- SSPRXINTR is sampled only on the LSB-completing edge. A FIFO read in the same cycle does not rescue the frame. A full FIFO never stalls shifting.
- CLEAR_B low (any time, including mid-frame): state=IDLE, bit_cnt=0, shift=0, RxData=0, write_ready=0, rx_overrun=0, s_clk=clk_d=0, s_fss=0, s_rxd=0. A partial frame is discarded. After release, the block waits for a new FSS.

## Timing
- Reset values: RxData=0, write_ready=0, rx_overrun=0, rx_busy=0.
- Pin-to-detect: the SSPCLKIN fall is captured at PCLK edge E1, fall is true in the cycle after E1, and action happens at E2.
- Latency: write_ready goes high after E2 of the LSB fall and is high for exactly one PCLK. RxData updates at the same edge.
- Minimum frame period: DATA_WIDTH SSPCLKIN periods when back-to-back (FSS coincident with the LSB). This gives ≥ 2·DATA_WIDTH PCLK between write_ready strobes.
- Rising edges of SSPCLKIN cause no action.

## Test plan
- Reset: hold CLEAR_B=0 with inputs toggling → all outputs 0. Release, then FSS + 0xA5 at SSPCLKIN=PCLK/2 → single write_ready pulse 2 PCLK after the LSB fall is sampled, RxData=0xA5, rx_busy low afterward.
- Back-to-back: FSS asserted during the LSB of 0x3C, followed by 0xC3 with no idle bit → two write_ready pulses 16 PCLK apart, RxData sequence 0x3C then 0xC3.
- Overrun: SSPRXINTR=1 at completion of 0x5A → rx_overrun one-cycle pulse, write_ready stays 0, RxData keeps its previous value. Next frame 0x81 with SSPRXINTR=0 → accepted normally.
- Noise: SSPCLKIN toggles with SSPFSSIN=0 → no state change. FSS pulse mid-frame (bit 3) of 0xF0 → ignored, RxData=0xF0.
- Reset mid-operation: CLEAR_B pulsed low after 4 bits → no write_ready. Next complete frame 0x12 → RxData=0x12.
- Slow clock: SSPCLKIN=PCLK/8 with 0xFF then 0x00 → exactly one write_ready per frame, correct data.

Source files
------------

// File: rtl/ssp_rx_deserializer.sv
// SSP receive deserializer: samples a TI-format serial stream in the PCLK domain,
// assembles MSB-first frames and hands each one to the receive FIFO with a write strobe.
module ssp_rx_deserializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  SSPCLKIN,
  input  logic                  SSPFSSIN,
  input  logic                  SSPRXD,
  input  logic                  SSPRXINTR,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  write_ready,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  // Input sampling stage
  logic s_clk_q,   s_clk_d;
  logic clk_dly_q, clk_dly_d;
  logic s_fss_q,   s_fss_d;
  logic s_rxd_q,   s_rxd_d;

  // Protocol state
  state_e                  state_q,       state_d;
  logic [CNT_W-1:0]        bit_cnt_q,     bit_cnt_d;
  logic [DATA_WIDTH-2:0]   shift_q,       shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q,     rx_data_d;
  logic                    write_ready_q, write_ready_d;
  logic                    rx_overrun_q,  rx_overrun_d;

  logic                    fall;
  logic [DATA_WIDTH-1:0]   frame;

  // Falling edge of the peer clock as seen through the sampling stage.
  assign fall  = clk_dly_q & ~s_clk_q;
  assign frame = {shift_q, s_rxd_q};

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    s_clk_d       = SSPCLKIN;
    clk_dly_d     = s_clk_q;
    s_fss_d       = SSPFSSIN;
    s_rxd_d       = SSPRXD;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    write_ready_d = 1'b0;
    rx_overrun_d  = 1'b0;

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (s_fss_q) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = frame[DATA_WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            // FIFO full at the LSB drops the frame; shifting itself never stalls.
            if (SSPRXINTR) begin
              rx_overrun_d = 1'b1;
            end else begin
              rx_data_d     = frame;
              write_ready_d = 1'b1;
            end
            bit_cnt_d = '0;
            state_d   = s_fss_q ? SHIFT : IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: RxData is a single visible register, not a memory, so it is reset along
  // with the control state to give the FIFO a defined value after CLEAR_B.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      s_clk_q       <= 1'b0;
      clk_dly_q     <= 1'b0;
      s_fss_q       <= 1'b0;
      s_rxd_q       <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      write_ready_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      s_clk_q       <= s_clk_d;
      clk_dly_q     <= clk_dly_d;
      s_fss_q       <= s_fss_d;
      s_rxd_q       <= s_rxd_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      write_ready_q <= write_ready_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign RxData      = rx_data_q;
  assign write_ready = write_ready_q;
  assign rx_overrun  = rx_overrun_q;
  assign rx_busy     = (state_q == SHIFT);

endmodule
